// File: rtl/fp_noncomp_pipe.sv
// Non-computational FP lane: CLASSIFY, MINMAX and CMP over the enabled FP32/FP16/FP8/FP16ALT formats.
// Latency: NumPipeRegs cycles (0 = purely combinational, in_ready_o follows out_ready_i).
// Backpressure: valid/ready per stage; a stalled full pipe holds NumPipeRegs ops and drops in_ready_o.
// Ports: clk_i/rst_i (sync, active-high), flush_i; op_i/rnd_mode_i/fmt_i/op_a_i/op_b_i/tag_i with
//    in_valid_i/in_ready_o; result_o/status_o/tag_o with out_valid_o/out_ready_i; busy_o.
module fp_noncomp_pipe #(
   parameter logic [4:0]  FpFmtConfig  = 5'b10000,
   parameter int unsigned Width        = 32,
   parameter bit          EnableNanBox = 1'b1,
   parameter int unsigned NumPipeRegs  = 1,
   parameter int unsigned TagWidth     = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   input  logic [3:0]          op_i,
   input  logic [2:0]          rnd_mode_i,
   input  logic [2:0]          fmt_i,
   input  logic [Width-1:0]    op_a_i,
   input  logic [Width-1:0]    op_b_i,
   input  logic [TagWidth-1:0] tag_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   output logic [Width-1:0]    result_o,
   output logic [4:0]          status_o,
   output logic [TagWidth-1:0] tag_o,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic                busy_o
);

   localparam logic [3:0] OP_MINMAX   = 4'd7;
   localparam logic [3:0] OP_CMP      = 4'd8;
   localparam logic [3:0] OP_CLASSIFY = 4'd9;

   localparam logic [2:0] RM_RNE = 3'd0;
   localparam logic [2:0] RM_RTZ = 3'd1;
   localparam logic [2:0] RM_RDN = 3'd2;

   localparam logic [2:0] FMT_FP32    = 3'd0;
   localparam logic [2:0] FMT_FP64    = 3'd1;
   localparam logic [2:0] FMT_FP16    = 3'd2;
   localparam logic [2:0] FMT_FP8     = 3'd3;
   localparam logic [2:0] FMT_FP16ALT = 3'd4;

   localparam logic [4:0] ST_NV = 5'b10000;

   // Operands are zero-extended by 32 bits so fixed FP32 slices stay legal for any Width.
   localparam int unsigned XW = Width + 32;

   typedef struct packed {
      logic             sign;
      logic [30:0]      mag;         // exponent|mantissa, orders like an unsigned number
      logic             zero;
      logic             inf;
      logic             nan;
      logic             snan;
      logic             sub;
      logic             norm;
      logic [Width-1:0] boxed;       // operand as it would be returned by MINMAX
      logic [Width-1:0] qnan_boxed;  // canonical qNaN of this format
   } info_t;

   typedef struct packed {
      logic [Width-1:0]    res;
      logic [4:0]          st;
      logic [TagWidth-1:0] tag;
   } slot_t;

   // Config bit 4 is FP32, bit 0 is FP16ALT (format index counts from the MSB).
   function automatic logic fmt_enabled(input logic [2:0] fmt);
      logic en;
      case (fmt)
         FMT_FP32:    en = FpFmtConfig[4];
         FMT_FP64:    en = FpFmtConfig[3];
         FMT_FP16:    en = FpFmtConfig[2];
         FMT_FP8:     en = FpFmtConfig[1];
         FMT_FP16ALT: en = FpFmtConfig[0];
         default:     en = 1'b0;
      endcase
      return en;
   endfunction

   function automatic info_t decode(input logic [Width-1:0] op, input logic [2:0] fmt);
      info_t          r;
      logic [XW-1:0]  x;
      logic [XW-1:0]  rx;
      logic [XW-1:0]  qx;
      logic [31:0]    qnan;
      logic [31:0]    raw;
      int unsigned    fw;
      logic           box_ok;
      logic           e_ones;
      logic           e_zero;
      logic           m_zero;
      logic           m_msb;
      x = {32'b0, op};
      case (fmt)
         FMT_FP16:    begin fw = 16; qnan = 32'h0000_7E00; end
         FMT_FP8:     begin fw = 8;  qnan = 32'h0000_007E; end
         FMT_FP16ALT: begin fw = 16; qnan = 32'h0000_7FC0; end
         default:     begin fw = 32; qnan = 32'h7FC0_0000; end
      endcase
      // A narrow value not padded with ones above its width reads as canonical qNaN.
      box_ok = 1'b1;
      for (int unsigned i = 0; i < Width; i++) begin
         if (EnableNanBox && (i >= fw) && !op[i]) box_ok = 1'b0;
      end
      raw = box_ok ? x[31:0] : qnan;
      r   = '0;
      case (fmt)
         FMT_FP16: begin
            r.sign = raw[15]; e_ones = &raw[14:10]; e_zero = ~|raw[14:10];
            m_zero = ~|raw[9:0]; m_msb = raw[9]; r.mag = {16'b0, raw[14:0]};
         end
         FMT_FP8: begin
            r.sign = raw[7]; e_ones = &raw[6:2]; e_zero = ~|raw[6:2];
            m_zero = ~|raw[1:0]; m_msb = raw[1]; r.mag = {24'b0, raw[6:0]};
         end
         FMT_FP16ALT: begin
            r.sign = raw[15]; e_ones = &raw[14:7]; e_zero = ~|raw[14:7];
            m_zero = ~|raw[6:0]; m_msb = raw[6]; r.mag = {16'b0, raw[14:0]};
         end
         default: begin
            r.sign = raw[31]; e_ones = &raw[30:23]; e_zero = ~|raw[30:23];
            m_zero = ~|raw[22:0]; m_msb = raw[22]; r.mag = raw[30:0];
         end
      endcase
      r.nan  = e_ones && !m_zero;
      r.snan = e_ones && !m_zero && !m_msb;
      r.inf  = e_ones && m_zero;
      r.zero = e_zero && m_zero;
      r.sub  = e_zero && !m_zero;
      r.norm = !e_ones && !e_zero;
      rx = {{Width{1'b0}}, raw};
      qx = {{Width{1'b0}}, qnan};
      for (int unsigned i = 0; i < Width; i++) begin
         r.boxed[i]      = (i < fw) ? rx[i] : EnableNanBox;
         r.qnan_boxed[i] = (i < fw) ? qx[i] : EnableNanBox;
      end
      return r;
   endfunction

   function automatic logic [9:0] classmask(input info_t v);
      logic [9:0] m;
      if (v.nan)       m = v.snan ? 10'h100 : 10'h200;
      else if (v.inf)  m = v.sign ? 10'h001 : 10'h080;
      else if (v.norm) m = v.sign ? 10'h002 : 10'h040;
      else if (v.sub)  m = v.sign ? 10'h004 : 10'h020;
      else             m = v.sign ? 10'h008 : 10'h010;
      return m;
   endfunction

   info_t            a_dec;
   info_t            b_dec;
   logic             legal;
   logic             a_lt;       // total order, -0 below +0
   logic             both_zero;
   logic             eq;
   logic [Width-1:0] op_res;
   logic [4:0]       op_st;
   slot_t            in_dat;

   always_comb begin
      a_dec     = decode(op_a_i, fmt_i);
      b_dec     = decode(op_b_i, fmt_i);
      op_res    = '0;
      op_st     = '0;
      both_zero = a_dec.zero && b_dec.zero;
      eq        = both_zero || ((a_dec.sign == b_dec.sign) && (a_dec.mag == b_dec.mag));
      if (a_dec.sign != b_dec.sign) a_lt = a_dec.sign;
      else if (a_dec.sign)          a_lt = a_dec.mag > b_dec.mag;
      else                          a_lt = a_dec.mag < b_dec.mag;

      case (op_i)
         OP_MINMAX:   legal = (rnd_mode_i == RM_RNE) || (rnd_mode_i == RM_RTZ);
         OP_CMP:      legal = (rnd_mode_i == RM_RNE) || (rnd_mode_i == RM_RTZ) ||
                              (rnd_mode_i == RM_RDN);
         OP_CLASSIFY: legal = 1'b1;
         default:     legal = 1'b0;
      endcase
      legal = legal && fmt_enabled(fmt_i);

      if (!legal) begin
         op_st = ST_NV;
      end else begin
         case (op_i)
            OP_CLASSIFY: op_res[9:0] = classmask(a_dec);
            OP_MINMAX: begin
               if (a_dec.nan && b_dec.nan)   op_res = a_dec.qnan_boxed;
               else if (a_dec.nan)           op_res = b_dec.boxed;
               else if (b_dec.nan)           op_res = a_dec.boxed;
               else if (rnd_mode_i == RM_RNE) op_res = a_lt ? a_dec.boxed : b_dec.boxed;
               else                          op_res = a_lt ? b_dec.boxed : a_dec.boxed;
               op_st[4] = a_dec.snan || b_dec.snan;
            end
            OP_CMP: begin
               if (a_dec.nan || b_dec.nan) begin
                  // Ordered compares signal on any NaN, EQ only on signalling ones.
                  op_st[4] = (rnd_mode_i == RM_RDN) ? (a_dec.snan || b_dec.snan) : 1'b1;
               end else begin
                  case (rnd_mode_i)
                     RM_RNE:  op_res[0] = (a_lt && !both_zero) || eq;
                     RM_RTZ:  op_res[0] = a_lt && !both_zero;
                     default: op_res[0] = eq;
                  endcase
               end
            end
            default: op_st = ST_NV;
         endcase
      end
      in_dat = {op_res, op_st, tag_i};
   end

   generate
      if (NumPipeRegs == 0) begin : g_comb
         assign in_ready_o  = out_ready_i | flush_i;
         assign out_valid_o = in_valid_i;
         assign result_o    = in_dat.res;
         assign status_o    = in_dat.st;
         assign tag_o       = in_dat.tag;
         assign busy_o      = 1'b0;
      end else begin : g_pipe
         localparam int unsigned N = NumPipeRegs;

         logic [N-1:0] vld;
         slot_t        dat [N];
         logic [N-1:0] rdy;      // stage k may load this cycle
         logic [N-1:0] nxt_vld;
         slot_t        nxt_dat [N];

         // Ready ripples back from the output: a stage loads if empty or if its successor loads.
         always_comb begin : p_rdy
            logic r;
            r   = out_ready_i;
            rdy = '0;
            for (int k = int'(N) - 1; k >= 0; k--) begin
               r      = !vld[k] || r;
               rdy[k] = r;
            end
         end

         for (genvar k = 0; k < N; k++) begin : g_nxt
            if (k == 0) begin : g_first
               assign nxt_vld[k] = in_valid_i;
               assign nxt_dat[k] = in_dat;
            end else begin : g_rest
               assign nxt_vld[k] = vld[k-1];
               assign nxt_dat[k] = dat[k-1];
            end
         end

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               vld <= '0;
               for (int k = 0; k < int'(N); k++) dat[k] <= '0;
            end else begin
               for (int k = 0; k < int'(N); k++) begin
                  if (rdy[k]) begin
                     vld[k] <= nxt_vld[k];
                     if (nxt_vld[k]) dat[k] <= nxt_dat[k];
                  end
               end
               if (flush_i) vld <= '0;
            end
         end

         assign in_ready_o  = rdy[0] | flush_i;
         assign out_valid_o = vld[N-1];
         assign result_o    = dat[N-1].res;
         assign status_o    = dat[N-1].st;
         assign tag_o       = dat[N-1].tag;
         assign busy_o      = |vld;
      end
   endgenerate

endmodule

// File: tb/tb_fp_noncomp_pipe.sv
// Directed bench for fp_noncomp_pipe with a two-stage pipe and FP32/FP16/FP8/FP16ALT enabled.
// Each op is sent alone and its result, status, tag and latency checked against hand values;
// then stall/ordering, flush and mid-stream reset sequences are exercised.
module tb_fp_noncomp_pipe;

   localparam logic [3:0] OP_ADD = 4'd2, OP_MINMAX = 4'd7, OP_CMP = 4'd8, OP_CLASS = 4'd9;
   localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3;
   localparam logic [2:0] FP32 = 3'd0, FP64 = 3'd1, FP16 = 3'd2, FP8 = 3'd3, ALT = 3'd4;

   logic        clk_i = 1'b0;
   logic        rst_i, flush_i;
   logic [3:0]  op_i;
   logic [2:0]  rnd_mode_i, fmt_i;
   logic [31:0] op_a_i, op_b_i;
   logic [3:0]  tag_i;
   logic        in_valid_i, in_ready_o;
   logic [31:0] result_o;
   logic [4:0]  status_o;
   logic [3:0]  tag_o;
   logic        out_valid_o, out_ready_i, busy_o;

   int n_vec = 0;
   int n_bad = 0;

   fp_noncomp_pipe #(
      .FpFmtConfig (5'b10111),
      .Width       (32),
      .EnableNanBox(1'b1),
      .NumPipeRegs (2),
      .TagWidth    (4)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .flush_i    (flush_i),
      .op_i       (op_i),
      .rnd_mode_i (rnd_mode_i),
      .fmt_i      (fmt_i),
      .op_a_i     (op_a_i),
      .op_b_i     (op_b_i),
      .tag_i      (tag_i),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .result_o   (result_o),
      .status_o   (status_o),
      .tag_o      (tag_o),
      .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i),
      .busy_o     (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Send one op into an idle pipe and collect its output; lat counts edges from accept to out_valid.
   task automatic do_op(input logic [3:0] op, input logic [2:0] rm, input logic [2:0] fmt,
                        input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                        output logic [31:0] res, output logic [4:0] st, output logic [3:0] tg,
                        output int lat);
      int n;
      op_i = op; rnd_mode_i = rm; fmt_i = fmt; op_a_i = a; op_b_i = b; tag_i = tag;
      in_valid_i = 1'b1;
      #1;
      n = 0;
      while (!in_ready_o && n < 20) begin step(); n++; end
      step();
      in_valid_i = 1'b0;
      lat = 1;
      while (!out_valid_o && lat < 20) begin step(); lat++; end
      res = result_o; st = status_o; tg = tag_o;
      step();
   endtask

   task automatic vec(input string name, input logic [3:0] op, input logic [2:0] rm,
                      input logic [2:0] fmt, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input logic [31:0] er, input logic [4:0] es);
      logic [31:0] res;
      logic [4:0]  st;
      logic [3:0]  tg;
      int          lat;
      do_op(op, rm, fmt, a, b, tag, res, st, tg, lat);
      chk({name, "/res"}, 64'(res), 64'(er));
      chk({name, "/st"},  64'(st),  64'(es));
      chk({name, "/tag"}, 64'(tg),  64'(tag));
      chk({name, "/lat"}, 64'(lat), 64'd2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] res;
      logic [4:0]  st;
      logic [3:0]  tg;
      int          lat;
      int          sent, nout;
      logic        acc;
      logic [3:0]  otag [4];
      int          ocyc [4];

      rst_i = 1'b1; flush_i = 1'b0; op_i = '0; rnd_mode_i = '0; fmt_i = '0;
      op_a_i = '0; op_b_i = '0; tag_i = '0; in_valid_i = 1'b0; out_ready_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      #1;
      chk("rst/out_valid", 64'(out_valid_o), 64'd0);
      chk("rst/result",    64'(result_o),    64'd0);
      chk("rst/status",    64'(status_o),    64'd0);
      chk("rst/tag",       64'(tag_o),       64'd0);
      chk("rst/busy",      64'(busy_o),      64'd0);
      chk("rst/in_ready",  64'(in_ready_o),  64'd1);

      // Single-op vectors: name, op, rnd, fmt, A, B, tag, expected result, expected status.
      vec("class_neginf",  OP_CLASS,  RNE, FP32, 32'hFF80_0000, 32'h0,          4'd3, 32'h001, 5'h00);
      vec("min_snan",      OP_MINMAX, RNE, FP32, 32'h7FA0_0000, 32'h3F80_0000, 4'd4, 32'h3F80_0000, 5'h10);
      vec("min_badbox",    OP_MINMAX, RNE, FP16, 32'h0000_3C00, 32'hFFFF_C000, 4'd5, 32'hFFFF_C000, 5'h00);
      vec("cmp_eq_zeros",  OP_CMP,    RDN, FP32, 32'h8000_0000, 32'h0000_0000, 4'd6, 32'd1, 5'h00);
      vec("cmp_lt_zeros",  OP_CMP,    RTZ, FP32, 32'h8000_0000, 32'h0000_0000, 4'd7, 32'd0, 5'h00);
      vec("cmp_le_zeros",  OP_CMP,    RNE, FP32, 32'h8000_0000, 32'h0000_0000, 4'd8, 32'd1, 5'h00);
      vec("min_signzero",  OP_MINMAX, RNE, FP32, 32'h8000_0000, 32'h0000_0000, 4'd9, 32'h8000_0000, 5'h00);
      vec("max_signzero",  OP_MINMAX, RTZ, FP32, 32'h8000_0000, 32'h0000_0000, 4'hA, 32'h0000_0000, 5'h00);
      vec("max_pos",       OP_MINMAX, RTZ, FP32, 32'h3F80_0000, 32'h4000_0000, 4'hB, 32'h4000_0000, 5'h00);
      vec("min_neg",       OP_MINMAX, RNE, FP32, 32'hBF80_0000, 32'hC000_0000, 4'hC, 32'hC000_0000, 5'h00);
      vec("min_two_nan",   OP_MINMAX, RNE, FP16, 32'hFFFF_7D00, 32'hFFFF_7E00, 4'hD, 32'hFFFF_7E00, 5'h10);
      vec("cmp_lt_qnan",   OP_CMP,    RTZ, FP32, 32'h7FC0_0000, 32'h0000_0000, 4'hE, 32'd0, 5'h10);
      vec("cmp_eq_qnan",   OP_CMP,    RDN, FP32, 32'h7FC0_0000, 32'h0000_0000, 4'hF, 32'd0, 5'h00);
      vec("cmp_eq_snan",   OP_CMP,    RDN, FP32, 32'h7FA0_0000, 32'h7FA0_0000, 4'h1, 32'd0, 5'h10);
      vec("cmp_le_false",  OP_CMP,    RNE, FP32, 32'h4000_0000, 32'h3F80_0000, 4'h2, 32'd0, 5'h00);
      vec("cmp_lt_alt",    OP_CMP,    RTZ, ALT,  32'hFFFF_BF80, 32'hFFFF_3F80, 4'h0, 32'd1, 5'h00);
      vec("class_fp8",     OP_CLASS,  RNE, FP8,  32'hFFFF_FF3C, 32'h0,          4'h5, 32'h040, 5'h00);
      vec("class_badbox",  OP_CLASS,  RNE, FP16, 32'h0000_0001, 32'h0,          4'h6, 32'h200, 5'h00);
      vec("class_negsub",  OP_CLASS,  RNE, FP16, 32'hFFFF_8001, 32'h0,          4'h7, 32'h004, 5'h00);
      vec("ill_fmt",       OP_CLASS,  RNE, FP64, 32'h3F80_0000, 32'h0,          4'h8, 32'd0, 5'h10);
      vec("ill_op",        OP_ADD,    RNE, FP32, 32'h3F80_0000, 32'h3F80_0000, 4'h9, 32'd0, 5'h10);
      vec("ill_rm_minmax", OP_MINMAX, RDN, FP32, 32'h3F80_0000, 32'h4000_0000, 4'hA, 32'd0, 5'h10);
      vec("ill_rm_cmp",    OP_CMP,    RUP, FP32, 32'h3F80_0000, 32'h4000_0000, 4'hB, 32'd0, 5'h10);

      // Stall: output blocked for 6 cycles while 4 ops are offered back to back.
      op_i = OP_CLASS; rnd_mode_i = RNE; fmt_i = FP32; op_a_i = 32'h3F80_0000; op_b_i = '0;
      out_ready_i = 1'b0;
      sent = 0; nout = 0;
      for (int c = 0; c < 30; c++) begin
         if (c == 6) out_ready_i = 1'b1;
         in_valid_i = (sent < 4);
         tag_i = 4'(sent);
         #1;
         if (c == 5) begin
            chk("stall/accepts",  64'(sent),        64'd2);
            chk("stall/in_ready", 64'(in_ready_o),  64'd0);
            chk("stall/held_vld", 64'(out_valid_o), 64'd1);
            chk("stall/held_tag", 64'(tag_o),       64'd0);
         end
         if (out_valid_o && out_ready_i) begin
            if (nout < 4) begin
               otag[nout] = tag_o;
               ocyc[nout] = c;
            end
            nout++;
         end
         acc = in_valid_i && in_ready_o;
         step();
         if (acc) sent++;
      end
      in_valid_i = 1'b0;
      chk("stall/out_count", 64'(nout), 64'd4);
      for (int i = 0; i < 4; i++) begin
         chk("stall/order", 64'(otag[i]), 64'(i));
         chk("stall/no_gap", 64'(ocyc[i] - ocyc[0]), 64'(i));
      end

      // Flush with two ops in flight; an op offered in the flush cycle must vanish.
      op_i = OP_CLASS; fmt_i = FP32; op_a_i = 32'h3F80_0000;
      in_valid_i = 1'b1; tag_i = 4'd5; step();
      tag_i = 4'd6; step();
      out_ready_i = 1'b0; flush_i = 1'b1; tag_i = 4'd9;
      #1;
      chk("flush/in_ready", 64'(in_ready_o), 64'd1);
      step();
      flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
      #1;
      chk("flush/out_valid", 64'(out_valid_o), 64'd0);
      chk("flush/busy",      64'(busy_o),      64'd0);
      do_op(OP_MINMAX, RTZ, FP32, 32'h3F80_0000, 32'h4000_0000, 4'd7, res, st, tg, lat);
      chk("flush/new_res", 64'(res), 64'h4000_0000);
      chk("flush/new_tag", 64'(tg),  64'd7);
      chk("flush/new_lat", 64'(lat), 64'd2);
      chk("flush/drained", 64'(busy_o), 64'd0);

      // Same sequence with a reset in place of the flush.
      op_i = OP_CLASS; fmt_i = FP32; op_a_i = 32'h3F80_0000;
      in_valid_i = 1'b1; tag_i = 4'd5; step();
      tag_i = 4'd6; step();
      in_valid_i = 1'b0; rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      #1;
      chk("rst2/out_valid", 64'(out_valid_o), 64'd0);
      chk("rst2/result",    64'(result_o),    64'd0);
      chk("rst2/status",    64'(status_o),    64'd0);
      chk("rst2/tag",       64'(tag_o),       64'd0);
      chk("rst2/busy",      64'(busy_o),      64'd0);
      do_op(OP_CMP, RTZ, FP32, 32'hBF80_0000, 32'h3F80_0000, 4'd8, res, st, tg, lat);
      chk("rst2/new_res", 64'(res), 64'd1);
      chk("rst2/new_tag", 64'(tg),  64'd8);
      chk("rst2/new_lat", 64'(lat), 64'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
